bcd_reg_bank_param: RTL and testbench

//  Parametrised BCD register bank for the RTC/chronometer datapath (time, date, timer fields).

---
 rtl/bcd_reg_bank_param.sv | 199 +++++++++++++++++++
 tb/tb_bcd_reg_bank_param.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_reg_bank_param.sv
// Parametrised BCD register bank: range-checked bus writes, BCD step up/down with wrap, registered readback.
// Optional `SHADOW_SNAP_EN` adds a snapshot shadow bank that drives regs_flat for coherent display.
module bcd_reg_bank_param #(
  parameter int NUM_REGS = 9,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter logic [NUM_REGS*DATA_W-1:0] LIMIT_MAX = 72'h59_59_23_99_12_31_59_59_23,
  parameter logic [NUM_REGS*DATA_W-1:0] LIMIT_MIN = 72'h00_00_00_00_01_01_00_00_00
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       step_inc,
  input  logic                       step_dec,
  input  logic [ADDR_W-1:0]          step_addr,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       wr_err,
  output logic                       upd_stb,
  output logic [ADDR_W-1:0]          upd_addr,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  input  logic                       snap
);

  localparam int NDIG = DATA_W / 4;

  function automatic logic is_bcd(input logic [DATA_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int d = 0; d < NDIG; d++) begin
      if (v[d*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [DATA_W-1:0] bcd_inc(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    logic              c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < NDIG; d++) begin
      if (c) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] bcd_dec(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    logic              b;
    r = v;
    b = 1'b1;
    for (int d = 0; d < NDIG; d++) begin
      if (b) begin
        if (r[d*4 +: 4] == 4'd0) begin
          r[d*4 +: 4] = 4'd9;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [DATA_W-1:0]   r_regs     [NUM_REGS];
  logic [DATA_W-1:0]   w_reg_next [NUM_REGS];
  logic [NUM_REGS-1:0] w_wr_ok;
  logic [NUM_REGS-1:0] w_step_app;

  logic [DATA_W-1:0] r_rd_data;
  logic              r_wr_err;
  logic              r_upd_stb;
  logic [ADDR_W-1:0] r_upd_addr;

  logic              w_step_one;
  logic              w_step_collide;
  logic              w_wr_acc;
  logic              w_step_acc;
  logic [DATA_W-1:0] w_rd_val;
  logic [ADDR_W-1:0] w_upd_addr_next;

  assign w_step_one     = step_inc ^ step_dec;
  // A write to the stepped address swallows the step even when the write itself is rejected.
  assign w_step_collide = wr_en && (wr_addr == step_addr);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : gen_reg
    localparam logic [DATA_W-1:0] L_MAX  = LIMIT_MAX[gi*DATA_W +: DATA_W];
    localparam logic [DATA_W-1:0] L_MIN  = LIMIT_MIN[gi*DATA_W +: DATA_W];
    localparam logic [ADDR_W-1:0] L_ADDR = ADDR_W'(gi);

    logic              w_wr_hit;
    logic              w_step_hit;
    logic              w_in_range;
    logic [DATA_W-1:0] w_step_val;

    assign w_wr_hit    = wr_en && (wr_addr == L_ADDR);
    assign w_wr_ok[gi] = w_wr_hit && is_bcd(wr_data) &&
                         (wr_data >= L_MIN) && (wr_data <= L_MAX);
    assign w_step_hit  = w_step_one && (step_addr == L_ADDR) && !w_step_collide;
    assign w_step_app[gi] = w_step_hit;
    assign w_in_range  = is_bcd(r_regs[gi]) && (r_regs[gi] >= L_MIN) && (r_regs[gi] <= L_MAX);

    always_comb begin
      w_step_val = L_MIN;
      if (!w_in_range) begin
        w_step_val = L_MIN;
      end else if (step_inc) begin
        w_step_val = (r_regs[gi] == L_MAX) ? L_MIN : bcd_inc(r_regs[gi]);
      end else begin
        w_step_val = (r_regs[gi] == L_MIN) ? L_MAX : bcd_dec(r_regs[gi]);
      end
    end

    assign w_reg_next[gi] = w_wr_ok[gi] ? wr_data :
                            w_step_hit  ? w_step_val : r_regs[gi];
  end

  assign w_wr_acc   = |w_wr_ok;
  assign w_step_acc = |w_step_app;

  always_comb begin
    w_upd_addr_next = r_upd_addr;
    if (w_wr_acc) begin
      w_upd_addr_next = wr_addr;
    end else if (w_step_acc) begin
      w_upd_addr_next = step_addr;
    end
  end

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) w_rd_val = r_regs[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= LIMIT_MIN[i*DATA_W +: DATA_W];
      end
      r_rd_data  <= '0;
      r_wr_err   <= 1'b0;
      r_upd_stb  <= 1'b0;
      r_upd_addr <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= w_reg_next[i];
      end
      r_rd_data  <= w_rd_val;
      r_wr_err   <= wr_en && !w_wr_acc;
      r_upd_stb  <= w_wr_acc || w_step_acc;
      r_upd_addr <= w_upd_addr_next;
    end
  end

  assign rd_data  = r_rd_data;
  assign wr_err   = r_wr_err;
  assign upd_stb  = r_upd_stb;
  assign upd_addr = r_upd_addr;

`ifdef SHADOW_SNAP_EN
  logic [DATA_W-1:0] r_shadow [NUM_REGS];

  // Shadow captures the pre-edge live values, so a same-cycle write/step is not included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= LIMIT_MIN[i*DATA_W +: DATA_W];
      end
    end else if (snap) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= r_regs[i];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : gen_flat
    assign regs_flat[gi*DATA_W +: DATA_W] = r_shadow[gi];
  end
`else
  logic w_unused_snap;
  assign w_unused_snap = snap;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : gen_flat
    assign regs_flat[gi*DATA_W +: DATA_W] = r_regs[gi];
  end
`endif

endmodule

// File: tb/tb_bcd_reg_bank_param.sv
// Directed bench for bcd_reg_bank_param: vector table plus reset-abort and snapshot sequences.
module tb_bcd_reg_bank_param;

  localparam int NUM_REGS = 9;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 4;
  localparam logic [71:0] MIN_FLAT = 72'h00_00_00_00_01_01_00_00_00;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       step_inc;
  logic                       step_dec;
  logic [ADDR_W-1:0]          step_addr;
  logic [ADDR_W-1:0]          rd_addr;
  logic [DATA_W-1:0]          rd_data;
  logic                       wr_err;
  logic                       upd_stb;
  logic [ADDR_W-1:0]          upd_addr;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic                       snap;

  always #5 clk = ~clk;

  bcd_reg_bank_param #(
    .NUM_REGS(NUM_REGS),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .step_inc (step_inc),
    .step_dec (step_dec),
    .step_addr(step_addr),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_err   (wr_err),
    .upd_stb  (upd_stb),
    .upd_addr (upd_addr),
    .regs_flat(regs_flat),
    .snap     (snap)
  );

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       inc;
    logic       dec;
    logic [3:0] sa;
    logic [3:0] ra;
    logic       e_err;
    logic       e_upd;
    logic [3:0] e_ua;
    logic [7:0] e_rd;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  int n_cmp = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                              input logic inc, input logic dec, input logic [3:0] sa,
                              input logic [3:0] ra, input logic e_err, input logic e_upd,
                              input logic [3:0] e_ua, input logic [7:0] e_rd);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.inc = inc; v.dec = dec; v.sa = sa; v.ra = ra;
    v.e_err = e_err; v.e_upd = e_upd; v.e_ua = e_ua; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    step_inc = 1'b0; step_dec = 1'b0; step_addr = '0;
    rd_addr = '0; snap = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //             we wa     wd    inc dec sa     ra     err upd ua     rd
    vecs[0]  = mk(1, 4'd0, 8'h23, 0, 0, 4'd0,  4'd3,  0, 1, 4'd0, 8'h01);
    vecs[1]  = mk(1, 4'd0, 8'h24, 0, 0, 4'd0,  4'd0,  1, 0, 4'd0, 8'h23);
    vecs[2]  = mk(0, 4'd0, 8'h00, 0, 0, 4'd0,  4'd0,  0, 0, 4'd0, 8'h23);
    vecs[3]  = mk(1, 4'd1, 8'h1A, 0, 0, 4'd0,  4'd1,  1, 0, 4'd0, 8'h00);
    vecs[4]  = mk(1, 4'd9, 8'h05, 0, 0, 4'd0,  4'd1,  1, 0, 4'd0, 8'h00);
    vecs[5]  = mk(1, 4'd2, 8'h59, 0, 0, 4'd0,  4'd9,  0, 1, 4'd2, 8'h00);
    vecs[6]  = mk(0, 4'd0, 8'h00, 1, 0, 4'd2,  4'd2,  0, 1, 4'd2, 8'h59);
    vecs[7]  = mk(0, 4'd0, 8'h00, 0, 1, 4'd3,  4'd2,  0, 1, 4'd3, 8'h00);
    vecs[8]  = mk(1, 4'd4, 8'h09, 0, 0, 4'd0,  4'd3,  0, 1, 4'd4, 8'h31);
    vecs[9]  = mk(0, 4'd0, 8'h00, 1, 0, 4'd4,  4'd4,  0, 1, 4'd4, 8'h09);
    vecs[10] = mk(0, 4'd0, 8'h00, 1, 1, 4'd2,  4'd4,  0, 0, 4'd0, 8'h10);
    vecs[11] = mk(1, 4'd1, 8'h45, 1, 0, 4'd1,  4'd2,  0, 1, 4'd1, 8'h00);
    vecs[12] = mk(0, 4'd0, 8'h00, 0, 0, 4'd0,  4'd1,  0, 0, 4'd0, 8'h45);
    vecs[13] = mk(1, 4'd1, 8'h60, 1, 0, 4'd1,  4'd1,  1, 0, 4'd0, 8'h45);
    vecs[14] = mk(1, 4'd5, 8'h99, 0, 1, 4'd6,  4'd1,  0, 1, 4'd5, 8'h45);
    vecs[15] = mk(0, 4'd0, 8'h00, 1, 0, 4'd5,  4'd6,  0, 1, 4'd5, 8'h23);
    vecs[16] = mk(0, 4'd0, 8'h00, 1, 0, 4'd12, 4'd5,  0, 0, 4'd0, 8'h00);
    vecs[17] = mk(1, 4'd7, 8'h19, 0, 0, 4'd0,  4'd6,  0, 1, 4'd7, 8'h23);
    vecs[18] = mk(0, 4'd0, 8'h00, 1, 0, 4'd7,  4'd7,  0, 1, 4'd7, 8'h19);
    vecs[19] = mk(0, 4'd0, 8'h00, 0, 1, 4'd7,  4'd7,  0, 1, 4'd7, 8'h20);
    vecs[20] = mk(0, 4'd0, 8'h00, 0, 0, 4'd0,  4'd7,  0, 0, 4'd0, 8'h19);
    vecs[21] = mk(1, 4'd3, 8'h00, 0, 0, 4'd0,  4'd3,  1, 0, 4'd0, 8'h31);
    vecs[22] = mk(1, 4'd3, 8'h32, 0, 0, 4'd0,  4'd3,  1, 0, 4'd0, 8'h31);
    vecs[23] = mk(1, 4'd8, 8'h59, 0, 1, 4'd0,  4'd0,  0, 1, 4'd8, 8'h23);
    vecs[24] = mk(0, 4'd0, 8'h00, 0, 0, 4'd0,  4'd0,  0, 0, 4'd0, 8'h22);
    vecs[25] = mk(0, 4'd0, 8'h00, 0, 0, 4'd0,  4'd8,  0, 0, 4'd0, 8'h59);

    idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("reset_rd_data", rd_data, 8'h00);
    chk("reset_wr_err", wr_err, 1'b0);
    chk("reset_upd_stb", upd_stb, 1'b0);
    chk("reset_upd_addr", upd_addr, 4'd0);
    chk("reset_regs_flat", regs_flat, MIN_FLAT);
    $display("reset: regs_flat=%h rd_data=%h", regs_flat, rd_data);

    for (int i = 0; i < NV; i++) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      step_inc = vecs[i].inc; step_dec = vecs[i].dec; step_addr = vecs[i].sa;
      rd_addr = vecs[i].ra;
      tick();
      chk($sformatf("v%0d_wr_err", i), wr_err, vecs[i].e_err);
      chk($sformatf("v%0d_upd_stb", i), upd_stb, vecs[i].e_upd);
      if (vecs[i].e_upd) chk($sformatf("v%0d_upd_addr", i), upd_addr, vecs[i].e_ua);
      chk($sformatf("v%0d_rd_data", i), rd_data, vecs[i].e_rd);
      $display("vec %0d: we=%0d wa=%0d wd=%h inc=%0d dec=%0d sa=%0d ra=%0d -> err=%0d upd=%0d ua=%0d rd=%h",
               i, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].inc, vecs[i].dec, vecs[i].sa,
               vecs[i].ra, wr_err, upd_stb, upd_addr, rd_data);
    end

    // Reset asserted with a write and a step pending: both must be aborted.
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h11;
    step_inc = 1'b1; step_addr = 4'd2; rd_addr = 4'd1;
    reset = 1'b1;
    tick();
    chk("midrst_upd_stb", upd_stb, 1'b0);
    chk("midrst_wr_err", wr_err, 1'b0);
    chk("midrst_rd_data", rd_data, 8'h00);
    idle();
    reset = 1'b0;
    $display("mid-reset: upd=%0d err=%0d rd=%h", upd_stb, wr_err, rd_data);

    // First edge after release behaves normally.
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h12; rd_addr = 4'd1;
    tick();
    chk("postrst_upd_stb", upd_stb, 1'b1);
    chk("postrst_upd_addr", upd_addr, 4'd0);
    chk("postrst_rd_min", rd_data, 8'h00);
    idle();
    rd_addr = 4'd0;
    tick();
    chk("postrst_rd_hora", rd_data, 8'h12);
    $display("post-reset: upd=%0d ua=%0d rd=%h", upd_stb, upd_addr, rd_data);

    // Snapshot sequence; hora holds 12h here.
    snap = 1'b1;
    tick();
    chk("snap1_flat_hora", regs_flat[7:0], 8'h12);
    $display("snap1: flat_hora=%h", regs_flat[7:0]);
    idle();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h15;
    tick();
`ifdef SHADOW_SNAP_EN
    chk("wr15_flat_hora", regs_flat[7:0], 8'h12);
`else
    chk("wr15_flat_hora", regs_flat[7:0], 8'h15);
`endif
    $display("write 15: flat_hora=%h", regs_flat[7:0]);
    idle();
    rd_addr = 4'd0;
    tick();
    chk("wr15_rd_live", rd_data, 8'h15);
`ifdef SHADOW_SNAP_EN
    chk("wr15_flat_hold", regs_flat[15:0], 16'h0012);
`else
    chk("wr15_flat_hold", regs_flat[15:0], 16'h0015);
`endif
    $display("readback: rd=%h flat_lo=%h", rd_data, regs_flat[15:0]);
    idle();
    snap = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h16;
    tick();
`ifdef SHADOW_SNAP_EN
    chk("snap2_flat_hora", regs_flat[7:0], 8'h15);
`else
    chk("snap2_flat_hora", regs_flat[7:0], 8'h16);
`endif
    $display("snap2+write 16: flat_hora=%h", regs_flat[7:0]);
    idle();
    rd_addr = 4'd0;
    tick();
    chk("snap2_rd_live", rd_data, 8'h16);
`ifdef SHADOW_SNAP_EN
    chk("snap2_flat_hold", regs_flat[7:0], 8'h15);
`else
    chk("snap2_flat_hold", regs_flat[7:0], 8'h16);
`endif
    $display("final: rd=%h flat_hora=%h", rd_data, regs_flat[7:0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
